pc_rr_scheduler: RTL and testbench
==================================

// Module: pc_rr_scheduler
// PURPOSE
//  Program counter with a multi-slot round-robin process context unit. It holds
//  the OS PC and up to NPROC saved process PCs, and dispatches processes on OS
//  request. Each process is pre-empted back to the OS when its time quantum expires.
//  Instruction steps stall on I/O until the user toggles enter. Sits between
//  next-PC logic and instruction memory; also drives base/data relocation and
//  register-bank remap (r31/r28) for the datapath.
// PARAMETERS
//  ADDR_WIDTH  5   register-index width; data/PC width DW = 2**ADDR_WIDTH
//  NPROC       4   number of process context slots (>=2)
//  PID_W       2   slot index width, = clog2(NPROC)
//  QUANT_W     16  quantum counter width
// PORTS
//  clk            in   1        clock
//  reset          in   1        async active-high reset
//  next_pc        in   DW       PC+4 / branch / jump target from datapath
//  io_wait        in   1        current instruction is Input/Output
//  enter          in   1        user toggle; any level change releases one I/O stall
//  dispatch       in   1        OS requests switch to process dispatch_pid
//  dispatch_pid   in   PID_W    slot to run
//  dispatch_base  in   DW       process base (word index)
//  halt           in   1        running process executes halt
//  time_quantum   in   QUANT_W  steps per process slice (0 treated as 1)
//  pc_out         out  DW       current PC
//  base_addr      out  DW       instruction base = dispatch_base<<2 (0 in OS)
//  mem_addr       out  DW       data base = dispatch_base+16 (0 in OS)
//  cur_pid        out  PID_W    running slot (0 in OS)
//  in_os          out  1        1 = OS context
//  slot_valid     out  NPROC    slot holds a resumable saved PC
//  quantum_exp    out  1        one-cycle pulse on pre-emption
//  r31, r28       out  ADDR_WIDTH  {~in_os, 1..1} and {~in_os, 1..100}
// BEHAVIOUR
//  Reset: pc_out=0, base/mem=0, cur_pid=0, in_os=1, slot_valid=0, saved PCs=0,
//   os_ret=0, counter=1, quantum_exp=0, enter_prev=0; r31=0_1111, r28=0_1100.
//  step = !io_wait | (enter != enter_prev); on step with io_wait: enter_prev<=enter.
//   No step -> all state holds, quantum_exp=0. All actions below occur only on step.
//  States: OS_RUN, PROC_RUN (in_os = state==OS_RUN). r31/r28 combinational.
//  OS_RUN, !dispatch: pc_out<=next_pc.
//  OS_RUN, dispatch: os_ret<=next_pc; pc_out<=slot_valid[pid] ? saved_pc[pid]
//   : next_pc; base_addr<=dispatch_base<<2; mem_addr<=dispatch_base+16 (mod 2**DW);
//   cur_pid<=pid; counter<=1; ->PROC_RUN. dispatch ignored in PROC_RUN.
//  PROC_RUN, halt (priority): slot_valid[cur_pid]<=0, saved_pc<=0; pc_out<=os_ret;
//   base/mem/cur_pid<=0; counter<=1; ->OS_RUN; no quantum_exp.
//  PROC_RUN, counter>=max(time_quantum,1): saved_pc[cur_pid]<=next_pc;
//   slot_valid[cur_pid]<=1; pc_out<=os_ret; base/mem/cur_pid<=0; counter<=1;
//   quantum_exp<=1 for one cycle; ->OS_RUN.
//  PROC_RUN otherwise: pc_out<=next_pc; counter<=counter+1, saturating at all-ones.
//  A stalled I/O cycle never advances counter; quantum expiry is checked only on
//   the step that releases the stall.
//  time_quantum changes take effect on the next compare (no latch).
//  Reset mid-slice discards all contexts.
// TESTING
//  Reset, io_wait=0, next_pc=4,8,12 -> pc_out 4,8,12; in_os=1; r31=5'b01111.
//  OS dispatch pid=2 base=0x10, next_pc=0x40, quantum=3 -> pc_out=0x40,
//   base=0x40, mem=0x20, r31=5'b11111; 3rd step -> pc_out=os_ret, quantum_exp pulse,
//   slot_valid[2]=1.
//  Re-dispatch pid=2 -> pc_out=saved next_pc from the pre-empted step, not the new next_pc.
//  io_wait=1 held 5 cycles, enter static -> pc_out/counter frozen; toggle enter -> one step.
//  halt on same step as quantum expiry -> slot_valid[2]=0, quantum_exp=0, OS resumes.
//  time_quantum=0 -> pre-empt after 1 step; reset asserted in PROC_RUN -> all reset values.

Source files
------------

// File: rtl/pc_rr_scheduler.sv
// Program counter with an OS context and NPROC round-robin process slots.
// Processes run for a time quantum, then are pre-empted back to the OS with their PC saved.
module pc_rr_scheduler #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NPROC      = 4,
  parameter int unsigned PID_W      = 2,
  parameter int unsigned QUANT_W    = 16,
  localparam int unsigned DW        = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DW-1:0]         next_pc,
  input  logic                  io_wait,
  input  logic                  enter,
  input  logic                  dispatch,
  input  logic [PID_W-1:0]      dispatch_pid,
  input  logic [DW-1:0]         dispatch_base,
  input  logic                  halt,
  input  logic [QUANT_W-1:0]    time_quantum,
  output logic [DW-1:0]         pc_out,
  output logic [DW-1:0]         base_addr,
  output logic [DW-1:0]         mem_addr,
  output logic [PID_W-1:0]      cur_pid,
  output logic                  in_os,
  output logic [NPROC-1:0]      slot_valid,
  output logic                  quantum_exp,
  output logic [ADDR_WIDTH-1:0] r31,
  output logic [ADDR_WIDTH-1:0] r28
);

  localparam logic [0:0] OS_RUN   = 1'b0;
  localparam logic [0:0] PROC_RUN = 1'b1;

  localparam logic [ADDR_WIDTH-2:0] R31_LO = {(ADDR_WIDTH - 1){1'b1}};
  localparam logic [ADDR_WIDTH-2:0] R28_LO = {{(ADDR_WIDTH - 3){1'b1}}, 2'b00};

  logic [0:0]         state_q, state_d;
  logic [DW-1:0]      pc_q, pc_d;
  logic [DW-1:0]      base_q, base_d;
  logic [DW-1:0]      mem_q, mem_d;
  logic [PID_W-1:0]   pid_q, pid_d;
  logic [DW-1:0]      os_ret_q, os_ret_d;
  logic [NPROC-1:0]   valid_q, valid_d;
  logic [DW-1:0]      saved_q [NPROC];
  logic [DW-1:0]      saved_d [NPROC];
  logic [QUANT_W-1:0] cnt_q, cnt_d;
  logic               qexp_q, qexp_d;
  logic               enter_prev_q, enter_prev_d;

  logic               step;
  logic [QUANT_W-1:0] quant_eff;

  // An I/O instruction only advances when enter has changed level since the last release.
  assign step      = !io_wait || (enter != enter_prev_q);
  assign quant_eff = (time_quantum == '0) ? QUANT_W'(1) : time_quantum;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    base_d       = base_q;
    mem_d        = mem_q;
    pid_d        = pid_q;
    os_ret_d     = os_ret_q;
    valid_d      = valid_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    qexp_d       = 1'b0;
    enter_prev_d = enter_prev_q;

    if (step) begin
      if (io_wait) begin
        enter_prev_d = enter;
      end
      unique case (state_q)
        OS_RUN: begin
          if (dispatch) begin
            os_ret_d = next_pc;
            pc_d     = valid_q[dispatch_pid] ? saved_q[dispatch_pid] : next_pc;
            base_d   = dispatch_base << 2;
            mem_d    = dispatch_base + DW'(16);
            pid_d    = dispatch_pid;
            cnt_d    = QUANT_W'(1);
            state_d  = PROC_RUN;
          end else begin
            pc_d = next_pc;
          end
        end
        PROC_RUN: begin
          if (halt || (cnt_q >= quant_eff)) begin
            // Halt frees the slot; expiry keeps it resumable from the next instruction.
            valid_d[pid_q] = !halt;
            saved_d[pid_q] = halt ? '0 : next_pc;
            qexp_d         = !halt;
            pc_d           = os_ret_q;
            base_d         = '0;
            mem_d          = '0;
            pid_d          = '0;
            cnt_d          = QUANT_W'(1);
            state_d        = OS_RUN;
          end else begin
            pc_d = next_pc;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + QUANT_W'(1);
            end
          end
        end
        default: state_d = OS_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= OS_RUN;
      pc_q         <= '0;
      base_q       <= '0;
      mem_q        <= '0;
      pid_q        <= '0;
      os_ret_q     <= '0;
      valid_q      <= '0;
      cnt_q        <= QUANT_W'(1);
      qexp_q       <= 1'b0;
      enter_prev_q <= 1'b0;
      for (int i = 0; i < int'(NPROC); i++) begin
        saved_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      base_q       <= base_d;
      mem_q        <= mem_d;
      pid_q        <= pid_d;
      os_ret_q     <= os_ret_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      qexp_q       <= qexp_d;
      enter_prev_q <= enter_prev_d;
      saved_q      <= saved_d;
    end
  end

  assign pc_out      = pc_q;
  assign base_addr   = base_q;
  assign mem_addr    = mem_q;
  assign cur_pid     = pid_q;
  assign in_os       = (state_q == OS_RUN);
  assign slot_valid  = valid_q;
  assign quantum_exp = qexp_q;
  assign r31         = {~in_os, R31_LO};
  assign r28         = {~in_os, R28_LO};

endmodule

// File: tb/tb_pc_rr_scheduler.sv
// Bench for pc_rr_scheduler: directed scenarios then random traffic, each cycle compared
// against a slice-accounting reference model.
module tb_pc_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] next_pc = '0;
  logic        io_wait = 1'b0;
  logic        enter = 1'b0;
  logic        dispatch = 1'b0;
  logic [1:0]  dispatch_pid = '0;
  logic [31:0] dispatch_base = '0;
  logic        halt = 1'b0;
  logic [15:0] time_quantum = 16'd3;
  logic [31:0] pc_out, base_addr, mem_addr;
  logic [1:0]  cur_pid;
  logic        in_os, quantum_exp;
  logic [3:0]  slot_valid;
  logic [4:0]  r31, r28;

  int errors = 0;
  int checks = 0;

  pc_rr_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .io_wait      (io_wait),
    .enter        (enter),
    .dispatch     (dispatch),
    .dispatch_pid (dispatch_pid),
    .dispatch_base(dispatch_base),
    .halt         (halt),
    .time_quantum (time_quantum),
    .pc_out       (pc_out),
    .base_addr    (base_addr),
    .mem_addr     (mem_addr),
    .cur_pid      (cur_pid),
    .in_os        (in_os),
    .slot_valid   (slot_valid),
    .quantum_exp  (quantum_exp),
    .r31          (r31),
    .r28          (r28)
  );

  always #5 clk = ~clk;

  // Reference model: a process owns the CPU for a slice of max(quantum,1) steps.
  logic [31:0] m_pc, m_base, m_mem, m_osret;
  logic [1:0]  m_pid;
  logic        m_os, m_qexp, m_eprev;
  logic [3:0]  m_valid;
  logic [31:0] m_saved [4];
  int          m_used;

  task automatic model_reset();
    m_pc = 0; m_base = 0; m_mem = 0; m_osret = 0; m_pid = 0;
    m_os = 1; m_qexp = 0; m_eprev = 0; m_valid = 0; m_used = 0;
    for (int i = 0; i < 4; i++) m_saved[i] = 0;
  endtask

  task automatic leave_proc();
    m_pc = m_osret; m_base = 0; m_mem = 0; m_pid = 0; m_os = 1; m_used = 0;
  endtask

  task automatic model_step();
    int slice;
    m_qexp = 0;
    if (io_wait && (enter == m_eprev)) return;
    if (io_wait) m_eprev = enter;
    slice = (time_quantum == 0) ? 1 : int'(time_quantum);
    if (m_os) begin
      if (dispatch) begin
        m_osret = next_pc;
        m_pc    = m_valid[dispatch_pid] ? m_saved[dispatch_pid] : next_pc;
        m_base  = dispatch_base * 4;
        m_mem   = dispatch_base + 16;
        m_pid   = dispatch_pid;
        m_used  = 0;
        m_os    = 0;
      end else begin
        m_pc = next_pc;
      end
    end else if (halt) begin
      m_valid[m_pid] = 0;
      m_saved[m_pid] = 0;
      leave_proc();
    end else if (m_used + 1 >= slice) begin
      m_valid[m_pid] = 1;
      m_saved[m_pid] = next_pc;
      m_qexp = 1;
      leave_proc();
    end else begin
      m_pc = next_pc;
      m_used++;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(string tag);
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".base"}, base_addr, m_base);
    chk({tag, ".mem"}, mem_addr, m_mem);
    chk({tag, ".pid"}, 32'(cur_pid), 32'(m_pid));
    chk({tag, ".in_os"}, 32'(in_os), 32'(m_os));
    chk({tag, ".valid"}, 32'(slot_valid), 32'(m_valid));
    chk({tag, ".qexp"}, 32'(quantum_exp), 32'(m_qexp));
    chk({tag, ".r31"}, 32'(r31), m_os ? 32'h0f : 32'h1f);
    chk({tag, ".r28"}, 32'(r28), m_os ? 32'h0c : 32'h1c);
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    compare_all("reset");
    chk("reset_r31", 32'(r31), 32'h0f);
    chk("reset_r28", 32'(r28), 32'h0c);
    reset = 0;

    // OS sequencing
    next_pc = 32'd4;  tick("os4");  chk("os4_pc", pc_out, 32'd4);
    next_pc = 32'd8;  tick("os8");  chk("os8_pc", pc_out, 32'd8);
    next_pc = 32'd12; tick("os12"); chk("os12_pc", pc_out, 32'd12);
    chk("os_in_os", 32'(in_os), 32'd1);

    // Dispatch pid 2, quantum 3
    dispatch = 1; dispatch_pid = 2; dispatch_base = 32'h10; next_pc = 32'h40;
    tick("disp");
    dispatch = 0;
    chk("disp_pc", pc_out, 32'h40);
    chk("disp_base", base_addr, 32'h40);
    chk("disp_mem", mem_addr, 32'h20);
    chk("disp_r31", 32'(r31), 32'h1f);
    next_pc = 32'h44; tick("p1");
    next_pc = 32'h48; tick("p2");
    next_pc = 32'h4c; tick("p3");
    chk("exp_pc", pc_out, 32'h40);
    chk("exp_pulse", 32'(quantum_exp), 32'd1);
    chk("exp_valid2", 32'(slot_valid[2]), 32'd1);
    next_pc = 32'h100; tick("after_exp");
    chk("exp_pulse_end", 32'(quantum_exp), 32'd0);

    // Resume saved context rather than the new next_pc
    dispatch = 1; next_pc = 32'h200; tick("redisp");
    dispatch = 0;
    chk("redisp_pc", pc_out, 32'h4c);

    // I/O stall with enter held, then one toggle
    io_wait = 1; next_pc = 32'h300;
    for (int i = 0; i < 5; i++) tick("stall");
    chk("stall_pc", pc_out, 32'h4c);
    enter = 1; tick("release");
    chk("release_pc", pc_out, 32'h300);
    tick("stall2");
    chk("stall2_pc", pc_out, 32'h300);

    // Halt coincides with the expiry step
    io_wait = 0; next_pc = 32'h304; tick("p_h1");
    halt = 1; next_pc = 32'h308; tick("halt");
    halt = 0;
    chk("halt_pc", pc_out, 32'h200);
    chk("halt_valid2", 32'(slot_valid[2]), 32'd0);
    chk("halt_qexp", 32'(quantum_exp), 32'd0);
    chk("halt_in_os", 32'(in_os), 32'd1);

    // Quantum 0 behaves as 1
    time_quantum = 0; dispatch = 1; dispatch_pid = 1; dispatch_base = 32'hffff_fff8;
    next_pc = 32'h20; tick("q0_disp");
    dispatch = 0;
    chk("q0_mem_wrap", mem_addr, 32'h8);
    next_pc = 32'h24; tick("q0_exp");
    chk("q0_pc", pc_out, 32'h20);
    chk("q0_qexp", 32'(quantum_exp), 32'd1);

    // Asynchronous reset while a process runs
    time_quantum = 5; dispatch = 1; dispatch_pid = 3; dispatch_base = 32'h7;
    next_pc = 32'h80; tick("pre_rst");
    dispatch = 0;
    chk("pre_rst_in_os", 32'(in_os), 32'd0);
    reset = 1;
    #2;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    reset = 0;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      next_pc       = $urandom;
      io_wait       = ($urandom_range(3) == 0);
      if ($urandom_range(2) == 0) enter = ~enter;
      dispatch      = ($urandom_range(2) == 0);
      dispatch_pid  = 2'($urandom_range(3));
      dispatch_base = $urandom;
      halt          = ($urandom_range(7) == 0);
      time_quantum  = 16'($urandom_range(4));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
